core_debug_ctrl: RTL and testbench

Run/halt/step sequencer for the RV32I core, driven by a command channel (fed by the UART command decoder).
- Gates core progress with one enable, applied to PC update, RegWrite and MemWrite.
- Time-shares register file read port 1 between the core and debug reads while halted.
- Provides a single PC breakpoint and a retired-instruction counter; every command returns exactly one response.

---
 rtl/core_debug_ctrl_pkg.sv | 24 ++
 rtl/core_debug_ctrl.sv | 131 +++++++++++++
 tb/tb_core_debug_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_debug_ctrl_pkg.sv
// Shared opcode and state encodings for the core run/halt/step debug sequencer.
package core_debug_pkg;

  localparam int CMD_OP_W = 3;

  typedef enum logic [CMD_OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_HALT  = 3'd1,
    OP_RUN   = 3'd2,
    OP_STEP  = 3'd3,
    OP_RDREG = 3'd4,
    OP_RDPC  = 3'd5,
    OP_SETBP = 3'd6,
    OP_RDCYC = 3'd7
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_STEPX,
    ST_RESP
  } dbg_state_e;

endpackage

// File: rtl/core_debug_ctrl.sv
// Run/halt/step sequencer for the RV32I core: command/response channel, PC breakpoint,
// retired-instruction counter and register-file read port sharing while halted.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_READ  | debug owns rf read port 1 for one cycle
// ST_STEPX | core enabled for exactly one instruction
// ST_RESP  | response held until rsp_ready
module core_debug_ctrl
  import core_debug_pkg::*;
#(
  parameter bit RESET_RUN = 1'b1,
  parameter int XLEN      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CMD_OP_W-1:0] cmd_op,
  input  logic [4:0]          cmd_arg,
  input  logic [XLEN-1:0]     cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_data,
  output logic                rsp_err,
  input  logic [XLEN-1:0]     pc_in,
  input  logic [XLEN-1:0]     dbg_rdata,
  output logic                dbg_sel,
  output logic [4:0]          dbg_raddr,
  output logic                core_en,
  output logic                halted,
  output logic                halt_evt
);

  dbg_state_e      state;
  dbg_op_e         op;
  logic            run_flag;
  logic            skip_bp;
  logic            bp_valid;
  logic            bp_hit;
  logic            accept;
  logic            rsp_use_pc;
  logic [XLEN-1:0] bp_addr;
  logic [XLEN-1:0] cyc_cnt;
  logic [XLEN-1:0] rsp_data_r;
  logic [4:0]      arg_r;

  assign op        = dbg_op_e'(cmd_op);
  assign accept    = cmd_valid && (state == ST_IDLE);
  assign bp_hit    = run_flag && bp_valid && (pc_in == bp_addr) && !skip_bp;
  // Combinational so the instruction sitting at the breakpoint never retires.
  assign core_en   = (run_flag && !bp_hit) || (state == ST_STEPX);
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign halted    = !run_flag;
  assign dbg_sel   = (state == ST_READ);
  assign dbg_raddr = dbg_sel ? arg_r : 5'd0;
  // HALT/STEP report the PC after the core has stopped; it cannot move while halted.
  assign rsp_data  = rsp_use_pc ? pc_in : rsp_data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      run_flag   <= RESET_RUN;
      skip_bp    <= 1'b0;
      bp_valid   <= 1'b0;
      bp_addr    <= '0;
      cyc_cnt    <= '0;
      rsp_data_r <= '0;
      rsp_err    <= 1'b0;
      rsp_use_pc <= 1'b0;
      arg_r      <= '0;
      halt_evt   <= 1'b0;
    end else begin
      halt_evt <= bp_hit;
      if (core_en) begin
        cyc_cnt <= cyc_cnt + XLEN'(1);
        skip_bp <= 1'b0;
      end
      if (bp_hit) run_flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_data_r <= '0;
            rsp_err    <= 1'b0;
            rsp_use_pc <= 1'b0;
            state      <= ST_RESP;
            case (op)
              OP_HALT: begin
                run_flag   <= 1'b0;
                rsp_use_pc <= 1'b1;
              end
              OP_RUN: begin
                run_flag <= 1'b1;
                skip_bp  <= 1'b1;
              end
              OP_SETBP: begin
                bp_addr  <= cmd_data;
                bp_valid <= !cmd_arg[0];
              end
              OP_RDCYC: rsp_data_r <= cyc_cnt;
              OP_STEP, OP_RDREG, OP_RDPC: begin
                if (run_flag) begin
                  rsp_err <= 1'b1;
                end else if (op == OP_STEP) begin
                  state      <= ST_STEPX;
                  rsp_use_pc <= 1'b1;
                end else if (op == OP_RDREG) begin
                  state <= ST_READ;
                  arg_r <= cmd_arg;
                end else begin
                  rsp_data_r <= pc_in;
                end
              end
              default: ;
            endcase
          end
        end
        ST_READ: begin
          rsp_data_r <= dbg_rdata;
          state      <= ST_RESP;
        end
        ST_STEPX: state <= ST_RESP;
        ST_RESP:  if (rsp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Randomized bench for core_debug_ctrl: a toy core (PC += 4 per enabled cycle, small
// register file) plus a rule-level model of run/halt/breakpoint and command responses.
module tb_core_debug_ctrl;

  localparam bit RUN0 = 1'b0;
  localparam logic [2:0] OP_NOP = 3'd0, OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3,
                         OP_RDREG = 3'd4, OP_RDPC = 3'd5, OP_SETBP = 3'd6, OP_RDCYC = 3'd7;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_arg, dbg_raddr;
  logic [31:0] cmd_data, rsp_data, pc_in, dbg_rdata;
  logic        dbg_sel, core_en, halted, halt_evt;

  core_debug_ctrl #(.RESET_RUN(RUN0), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .pc_in(pc_in), .dbg_rdata(dbg_rdata), .dbg_sel(dbg_sel),
    .dbg_raddr(dbg_raddr), .core_en(core_en), .halted(halted), .halt_evt(halt_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Toy core: advances PC by 4 and optionally writes one register per enabled cycle.
  logic [31:0] regs [32];
  logic        en_q;
  logic [4:0]  wr_idx;
  logic [31:0] wr_val;

  assign dbg_rdata = regs[dbg_sel ? dbg_raddr : pc_in[6:2]];

  always @(negedge clk) en_q = core_en;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    forever begin
      @(posedge clk);
      #1;
      if (rst) pc_in = 32'h0;
      else if (en_q) begin
        pc_in = pc_in + 32'd4;
        if (wr_idx != 5'd0) regs[wr_idx] = wr_val;
      end
    end
  end

  int evt_cnt = 0;
  always @(negedge clk) if (halt_evt) evt_cnt++;

  // Accepted-command mailbox from the driver to the model.
  int          acc_cnt = 0;
  logic [2:0]  acc_op;
  logic [4:0]  acc_arg;
  logic [31:0] acc_data;

  // Reference model, evaluated once per cycle for the coming rising edge.
  int          acc_seen;
  logic        m_run, m_skip, m_bpv, m_evt, step_pend, halt_pend;
  logic [31:0] m_bpa, m_cyc;
  logic [31:0] exp_d;
  logic        exp_e;
  int          exp_lat;

  always @(negedge clk) begin
    logic bp_here, step_now, exp_en, take, was_run;
    #1;
    if (rst) begin
      m_run = RUN0; m_skip = 0; m_bpv = 0; m_bpa = 0; m_cyc = 0; m_evt = 0;
      step_pend = 0; halt_pend = 0; acc_seen = acc_cnt;
    end else begin
      was_run  = m_run;
      bp_here  = m_run && m_bpv && (pc_in == m_bpa) && !m_skip;
      step_now = step_pend;
      step_pend = 0;
      exp_en   = (m_run && !bp_here) || step_now;
      check("core_en", core_en, exp_en);
      check("halted", halted, !m_run);
      check("halt_evt", halt_evt, m_evt);
      m_evt = bp_here;
      if (halt_pend) begin exp_d = pc_in; halt_pend = 0; end
      if (step_now) exp_d = pc_in + 32'd4;
      take = (acc_cnt != acc_seen);
      acc_seen = acc_cnt;
      if (take) begin
        exp_d = 0; exp_e = 0; exp_lat = 1;
        case (acc_op)
          OP_RDCYC: exp_d = m_cyc;
          OP_STEP:  if (was_run) exp_e = 1; else exp_lat = 2;
          OP_RDREG: if (was_run) exp_e = 1; else begin exp_lat = 2; exp_d = regs[acc_arg]; end
          OP_RDPC:  if (was_run) exp_e = 1; else exp_d = pc_in;
          default: ;
        endcase
      end
      if (exp_en) begin m_cyc = m_cyc + 1; m_skip = 0; end
      if (bp_here) m_run = 0;
      if (take) begin
        case (acc_op)
          OP_HALT:  begin m_run = 0; halt_pend = 1; end
          OP_RUN:   begin m_run = 1; m_skip = 1; end
          OP_SETBP: begin m_bpa = acc_data; m_bpv = !acc_arg[0]; end
          OP_STEP:  if (!was_run) step_pend = 1;
          default: ;
        endcase
      end
    end
  end

  logic [31:0] last_d;
  logic        last_e;

  task automatic do_cmd(input logic [2:0] op, input logic [4:0] arg, input logic [31:0] data,
                        input int hold, input bit release_rsp);
    int n;
    int sel_n;
    @(negedge clk);
    cmd_op = op; cmd_arg = arg; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_accept", cmd_ready, 1'b1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    acc_op = op; acc_arg = arg; acc_data = data; acc_cnt++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    n = 1; sel_n = 0;
    while (!rsp_valid && n < 6) begin
      if (dbg_sel) begin sel_n++; check("dbg_raddr", dbg_raddr, arg); end
      @(negedge clk);
      n++;
    end
    #2;
    check("latency", n, exp_lat);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_err", rsp_err, exp_e);
    check("cmd_ready_in_resp", cmd_ready, 1'b0);
    if (op == OP_RDREG) check("dbg_sel_cycles", sel_n, (exp_lat == 2) ? 1 : 0);
    last_d = rsp_data;
    last_e = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      #2;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, last_d);
      check("hold_err", rsp_err, last_e);
      check("hold_ready", cmd_ready, 1'b0);
    end
    if (release_rsp) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_halted", halted, !RUN0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_halt_evt", halt_evt, 1'b0);
    check("rst_dbg_sel", dbg_sel, 1'b0);
    check("rst_dbg_raddr", dbg_raddr, 5'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, e0;
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 3'd0; cmd_arg = 5'd0;
    cmd_data = 32'h0; wr_idx = 5'd0; wr_val = 32'h0;
    #3;
    do_reset();

    do_cmd(OP_RDPC, 5'd0, 32'h0, 0, 1);
    check("rdpc_reset", last_d, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      do_cmd(OP_STEP, 5'd0, 32'h0, 0, 1);
      check("step_pc", last_d, 32'd4 * i);
    end
    do_cmd(OP_RDCYC, 5'd0, 32'h0, 0, 1);
    check("cyc_after_steps", last_d, 32'd3);

    wr_idx = 5'd5; wr_val = 32'hDEADBEEF;
    do_cmd(OP_RUN, 5'd0, 32'h0, 0, 1);
    repeat (3) @(negedge clk);
    do_cmd(OP_HALT, 5'd0, 32'h0, 0, 1);
    wr_idx = 5'd0;
    do_cmd(OP_RDREG, 5'd5, 32'h0, 0, 1);
    check("rdreg_x5", last_d, 32'hDEADBEEF);
    do_cmd(OP_RDREG, 5'd0, 32'h0, 0, 1);
    check("rdreg_x0", last_d, 32'h0);

    do_reset();
    do_cmd(OP_SETBP, 5'd0, 32'h10, 0, 1);
    do_cmd(OP_RUN, 5'd0, 32'h0, 0, 1);
    n = 0;
    while (!halted && n < 50) begin @(negedge clk); n++; end
    check("bp_stop_pc", pc_in, 32'h10);
    do_cmd(OP_RDPC, 5'd0, 32'h0, 0, 1);
    check("rdpc_at_bp", last_d, 32'h10);
    do_cmd(OP_RUN, 5'd0, 32'h0, 0, 1);
    repeat (4) @(negedge clk);
    check("bp_passed", pc_in > 32'h10, 1'b1);

    do_cmd(OP_STEP, 5'd0, 32'h0, 0, 1);
    check("step_running_err", last_e, 1'b1);
    do_cmd(OP_RDREG, 5'd3, 32'h0, 0, 1);
    check("rdreg_running_err", last_e, 1'b1);
    check("still_running", halted, 1'b0);

    do_cmd(OP_SETBP, 5'd0, 32'h100, 0, 1);
    @(negedge clk);
    n = 0;
    while (pc_in != 32'hFC && n < 200) begin @(negedge clk); n++; end
    check("reach_fc", pc_in, 32'hFC);
    e0 = evt_cnt;
    do_cmd(OP_HALT, 5'd0, 32'h0, 0, 1);
    check("halt_bp_pc", last_d, 32'h100);
    repeat (2) @(negedge clk);
    check("halt_evt_once", evt_cnt - e0, 1);

    do_cmd(OP_RDCYC, 5'd0, 32'h0, 5, 1);

    for (int k = 0; k < 150; k++) begin
      wr_idx = 5'($urandom_range(0, 31));
      wr_val = $urandom;
      do_cmd(3'($urandom_range(0, 7)), 5'($urandom), pc_in + 32'd4 * $urandom_range(0, 12),
             $urandom_range(0, 3), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wr_idx = 5'd0;

    do_cmd(OP_RUN, 5'd0, 32'h0, 0, 1);
    do_cmd(OP_RDCYC, 5'd0, 32'h0, 2, 0);
    do_reset();
    do_cmd(OP_RDCYC, 5'd0, 32'h0, 0, 1);
    check("cyc_after_reset", last_d, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
